// File: rtl/mem_lsu_port_if.sv
// Core request/response and memory-initiator signal bundle for mem_lsu_port.
// slave = the LSU itself, master = the core/memory environment driving it.
interface mem_lsu_port_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic [31:0]      mem_addr;
  logic [3:0]       mem_rmask;
  logic [3:0]       mem_wmask;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             mem_resp;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag, rsp_err,
    input  rsp_ready,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err,
    output rsp_ready,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_lsu_port.sv
// Single-outstanding load/store port: byte/half/word core requests onto a word-aligned, byte-masked memory bus.
// Build option MISALIGN_CHECK_EN: misaligned half/word accesses complete as errors instead of truncated issues.
module mem_lsu_port #(
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  mem_lsu_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;

  state_e           state_q, state_d;
  logic             init_q;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             accept;
  logic             req_bad;
  logic [1:0]       req_off;
  logic [31:0]      req_lane;
  logic [31:0]      rd_shift;
  logic [31:0]      load_data;
  logic [3:0]       size_mask;
  logic [3:0]       lane_mask;

  assign accept = bus.req_valid && init_q && (state_q == IDLE);

  always_comb begin
    req_off = bus.req_addr[1:0];
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: req_bad = 1'b0;
      3'b100, 3'b101:         req_bad = bus.req_we;
      default:                req_bad = 1'b1;
    endcase
`ifdef MISALIGN_CHECK_EN
    if ((bus.req_funct3[1:0] == 2'b01) && (req_off == 2'b11)) req_bad = 1'b1;
    if ((bus.req_funct3[1:0] == 2'b10) && (req_off != 2'b00)) req_bad = 1'b1;
`endif
    case (bus.req_funct3[1:0])
      2'b00:   req_lane = {24'b0, bus.req_wdata[7:0]};
      2'b01:   req_lane = {16'b0, bus.req_wdata[15:0]};
      default: req_lane = bus.req_wdata;
    endcase
  end

  // Bytes shifted past lane 3 fall off the top, which is the truncation a misaligned access gets.
  always_comb begin
    rd_shift = bus.mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'b0, rd_shift[7:0]};
      3'b101:  load_data = {16'b0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_bad ? DONE : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.mem_resp) state_d = DONE;
      DONE:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response fields are flops: DONE spends one cycle loading rsp_valid before the core sees it.
  always_comb begin
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_valid_d = (state_q == DONE) && !(rsp_valid_q && bus.rsp_ready);
    if (accept) begin
      we_d        = bus.req_we;
      funct3_d    = bus.req_funct3;
      off_d       = req_off;
      mem_addr_d  = {bus.req_addr[31:2], 2'b00};
      mem_wdata_d = bus.req_we ? (req_lane << {req_off, 3'b000}) : 32'h0;
      rsp_err_d   = req_bad;
      rsp_data_d  = 32'h0;
      rsp_tag_d   = bus.req_tag;
    end
    if ((state_q == WAIT) && bus.mem_resp) begin
      rsp_data_d = we_q ? 32'h0 : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_tag_q   <= '0;
    end else begin
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask     = size_mask << off_q;
    bus.req_ready = init_q && (state_q == IDLE);
    bus.mem_rmask = 4'b0000;
    bus.mem_wmask = 4'b0000;
    if (state_q == ISSUE) begin
      if (we_q) bus.mem_wmask = lane_mask;
      else      bus.mem_rmask = lane_mask;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;

endmodule
